pipe_stage_skid: RTL
====================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameter LANES, default 2, meaning the number of 32-bit-or-wider payload lanes carried (e.g. inst, NPC).
REQ-002 SHALL have parameter LANE_W, default 32, meaning the bit width of each lane.
REQ-003 SHALL have port clk  input  1  meaning the single clock, all state updated on its rising edge.
REQ-004 SHALL have port clr  input  1  meaning the reset, asynchronous and active-high.
REQ-005 SHALL have port flush  input  1  meaning a synchronous kill of all held entries.
REQ-006 SHALL have port in_valid  input  1  meaning the upstream stage presents a valid payload.
REQ-007 SHALL have port in_ready  output  1  meaning this stage can accept a payload; registered, no combinational path from out_ready.
REQ-008 SHALL have port in_data  input  LANES*LANE_W  meaning the upstream payload, lane 0 in the LSBs.
REQ-009 SHALL have port out_valid  output  1  meaning the main entry holds a valid payload.
REQ-010 SHALL have port out_ready  input  1  meaning the downstream stage accepts the payload this cycle (the inverse of its stall).
REQ-011 SHALL have port out_data  output  LANES*LANE_W  meaning the payload of the main entry.

Function
REQ-012 SHALL hold two entries: main (drives out_*) and skid; a transfer occurs on a valid&ready pair at a rising edge.
REQ-013 SHALL implement states EMPTY (no entry valid), ONE (main only), TWO (main and skid).
REQ-014 SHALL drive in_ready = 1 in EMPTY and ONE, and 0 in TWO.
REQ-015 In EMPTY: an in transfer loads main -> ONE; latency in_data to out_data is one cycle.
REQ-016 In ONE: in transfer with out_ready=1 replaces main -> ONE; in transfer with out_ready=0 loads skid -> TWO; no in and out_ready=1 -> EMPTY; otherwise hold.
REQ-017 In TWO: out_ready=1 moves skid to main -> ONE; out_ready=0 holds both; in_data is ignored.
REQ-018 SHALL never drop or duplicate a payload; the payload order at the output equals the acceptance order.
REQ-019 While out_valid=0, out_data SHALL be all-zero (a NOP bubble).
REQ-020 flush=1 SHALL take priority over every transfer: next state EMPTY, both entries zeroed, and the same-cycle in transfer discarded.
REQ-021 Held payloads SHALL be unchanged while the stage is stalled (out_ready=0).

Reset
REQ-022 clr=1 SHALL, asynchronously, force state EMPTY, out_valid=0, out_data=0, in_ready=1 and all entries to 0.
REQ-023 On clr deassertion mid-operation the stage SHALL restart from EMPTY; payloads in flight are lost by design.

Configuration
REQ-024 Macro PIPE_STAGE_SKID_PERF_EN: when defined, SHALL add output stall_cnt (16 bits), which counts cycles with out_valid=1 and out_ready=0.
REQ-025 stall_cnt SHALL saturate at 16'hFFFF, be cleared by clr and flush, and not be cleared by any other event.
REQ-026 When PIPE_STAGE_SKID_PERF_EN is undefined, the stall_cnt port and its logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-027 Package pipe_pkg SHALL hold the state enum (EMPTY/ONE/TWO), the LANE_W default and the NOP payload constant.
REQ-028 The saturating counter SHALL be a sub-module pipe_sat_cnt (parameter width), instantiated only under PIPE_STAGE_SKID_PERF_EN.

Verification
REQ-029 Reset: assert clr mid-stream in TWO -> out_valid=0, out_data=0 and in_ready=1 within the same cycle, with no clock edge required.
REQ-030 Streaming: in_valid=1 and out_ready=1 for 8 cycles with data 1..8 -> out_data 1..8 each one cycle later, with in_ready constantly 1.
REQ-031 Skid: in ONE holding A, drive B with out_ready=0 -> TWO and in_ready=0; raise out_ready -> outputs A then B, with C not accepted until in_ready=1.
REQ-032 Flush: in TWO, flush=1 together with in_valid=1 data D -> next cycle EMPTY, out_data=0, and D never appears at the output.
REQ-033 Random stalls: 1000 cycles of random in_valid and out_ready -> a scoreboard shows in-order, lossless, duplicate-free delivery.
REQ-034 Perf (macro defined): hold out_ready=0 for 70000 cycles with a payload valid -> stall_cnt=16'hFFFF; after flush, stall_cnt=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the skid-buffered pipeline stage.
package pipe_pkg;

   localparam int LANE_W_DEF = 32;

   // Wide enough for any practical LANES*LANE_W; users slice the low bits.
   localparam int                   NOP_MAX_W   = 4096;
   localparam logic [NOP_MAX_W-1:0] NOP_PAYLOAD = '0;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } pipe_state_e;

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle for one pipeline stage: upstream in_* channel and downstream out_* channel.
interface pipe_stage_skid_if
   import pipe_pkg::*;
#(
   parameter int LANES  = 2,
   parameter int LANE_W = LANE_W_DEF
);

   // A payload moves across a channel on a rising edge where valid and ready are both 1;
   // valid never waits on ready, and data is held stable while valid=1 and ready=0.
   logic                    in_valid;
   logic                    in_ready;
   logic [LANES*LANE_W-1:0] in_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [LANES*LANE_W-1:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with a synchronous clear; holds at all-ones.
module pipe_sat_cnt #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             clear_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] count_o
);

   logic [WIDTH-1:0] cnt_q;

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         cnt_q <= '0;
      end else if (clear_i) begin
         cnt_q <= '0;
      end else if (inc_i && (cnt_q != '1)) begin
         cnt_q <= cnt_q + WIDTH'(1);
      end
   end

   assign count_o = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry (main + skid) pipeline stage with fully registered in_ready.
// Optional stall counter enabled by defining PIPE_STAGE_SKID_PERF_EN.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int LANES  = 2,
   parameter int LANE_W = LANE_W_DEF
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic                    flush,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*LANE_W-1:0] in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*LANE_W-1:0] out_data,
`ifdef PIPE_STAGE_SKID_PERF_EN
   output logic [15:0]             stall_cnt,
`endif
   output pipe_state_e             dbg_state_o
);

   localparam int           W   = LANES * LANE_W;
   localparam logic [W-1:0] NOP = NOP_PAYLOAD[W-1:0];

   pipe_state_e  state_q;
   logic [W-1:0] main_q;
   logic [W-1:0] skid_q;
   logic         in_ready_q;
   logic         out_valid_q;

   // Empty entries are kept at NOP so out_data is a zero bubble without output muxing.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q     <= EMPTY;
         main_q      <= NOP;
         skid_q      <= NOP;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else if (flush) begin
         state_q     <= EMPTY;
         main_q      <= NOP;
         skid_q      <= NOP;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_valid) begin
                  main_q      <= in_data;
                  out_valid_q <= 1'b1;
                  state_q     <= ONE;
               end
            end
            ONE: begin
               if (in_valid && out_ready) begin
                  main_q <= in_data;
               end else if (in_valid) begin
                  skid_q     <= in_data;
                  in_ready_q <= 1'b0;
                  state_q    <= TWO;
               end else if (out_ready) begin
                  main_q      <= NOP;
                  out_valid_q <= 1'b0;
                  state_q     <= EMPTY;
               end
            end
            TWO: begin
               if (out_ready) begin
                  main_q     <= skid_q;
                  skid_q     <= NOP;
                  in_ready_q <= 1'b1;
                  state_q    <= ONE;
               end
            end
            default: begin
               state_q     <= EMPTY;
               main_q      <= NOP;
               skid_q      <= NOP;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_data    = main_q;
   assign dbg_state_o = state_q;

`ifdef PIPE_STAGE_SKID_PERF_EN
   pipe_sat_cnt #(
      .WIDTH (16)
   ) u_stall_cnt (
      .clk     (clk),
      .clr     (clr),
      .clear_i (flush),
      .inc_i   (out_valid_q && !out_ready),
      .count_o (stall_cnt)
   );
`endif

endmodule
